washing_machine_fill_controller: RTL and testbench
==================================================

// Module: washing_machine_fill_controller
// PURPOSE
//  Sequences the water-fill phase: weighs the load, picks the target water level from the
//  load-size bands, opens the inlet valve until the level sensor reaches the target, and
//  flags timeout or empty-drum faults. Sits between the cycle-level FSM (start/abort) and
//  the load cell, level sensor and inlet valve. Clock period is 200 ms (1 ms resolution).
// PARAMETERS
//  SETTLE_CYCLES  5      cycles waited after start before the first weight sample
//  FILL_TIMEOUT   600    max cycles with valve open before fault (600 x 200 ms = 2 min)
//  LOW_TH         8'd20  load_weight <= LOW_TH       -> LVL_LOW
//  MED_TH         8'd50  load_weight <= MED_TH       -> LVL_MED
//  HIGH_TH        8'd80  load_weight <= HIGH_TH      -> LVL_HIGH; above -> LVL_XHIGH
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   synchronous reset, active-low (0 = reset)
//  start         in   1   1-cycle pulse: begin weigh+fill; ignored unless IDLE
//  abort         in   1   level: return to IDLE, close valve; overrides all else except reset
//  load_weight   in   8   load-cell reading, unsigned
//  water_sensor  in   10  current drum water level, unsigned, same units as water_level
//  water_level   out  10  selected target level; 0 until a weigh completes
//  valve_open    out  1   inlet valve drive, high only in FILL
//  busy          out  1   high in WEIGH and FILL
//  fill_done     out  1   1-cycle pulse when target reached
//  fault         out  1   high in FAULT
//  fault_code    out  2   00 none, 01 empty drum, 10 fill timeout; valid while fault=1
// BEHAVIOUR
//  - All outputs registered. On reset=0 at a clock edge: state IDLE, water_level=0,
//    valve_open=0, busy=0, fill_done=0, fault=0, fault_code=00, all counters 0.
//    Reset mid-FILL closes the valve on that same edge.
//  - States: IDLE, SETTLE, WEIGH, FILL, DONE, FAULT (encoding in package).
//  - IDLE: start=1 -> SETTLE, settle counter cleared.
//  - SETTLE: counts SETTLE_CYCLES cycles, then -> WEIGH.
//  - WEIGH: accumulates load_weight on 4 consecutive cycles into a 10-bit sum (no overflow:
//    4*255=1020); avg = sum[9:2] (truncate). On the 4th sample's edge: avg==0 -> FAULT,
//    code 01; else water_level <= band(avg) and -> FILL.
//  - band(w): w<=LOW_TH->LVL_LOW=10'd150; <=MED_TH->LVL_MED=10'd300; <=HIGH_TH->
//    LVL_HIGH=10'd450; else LVL_XHIGH=10'd600. Threshold equality selects the lower band.
//  - FILL: valve_open=1; timeout counter increments each cycle. water_sensor>=water_level
//    -> DONE (valve closes on that edge). Counter reaching FILL_TIMEOUT-1 with sensor still
//    below target -> FAULT, code 10. Sensor reaching target on the timeout cycle: DONE wins.
//    Sensor already >= target on entry: DONE after exactly 1 FILL cycle.
//  - DONE: fill_done=1 for exactly one cycle, -> IDLE; water_level held until next weigh.
//  - FAULT: valve_open=0, fault=1, latched until abort=1 -> IDLE (fault, code cleared).
//    start ignored in FAULT.
//  - abort=1 in any state -> IDLE next edge; valve_open=0, busy=0, fill_done not pulsed;
//    water_level held. abort and start in the same cycle: abort wins.
//  - Latency: start to valve_open = SETTLE_CYCLES + 4 + 1 cycles.
//  - Inputs are sampled only in the states listed; load_weight changes during FILL ignored.
// STRUCTURE
//  - Package wm_fill_pkg: state enum/localparams, LVL_* constants, fault-code constants,
//    band() function (shared with the load-size detection block to keep thresholds single-
//    sourced).
//  - One sub-module: wm_weight_averager (4-sample accumulate, avg output, done pulse).
//  - FSM, timeout counter and output registers live in the top module.
// TESTING
//  1 Reset low mid-FILL with valve_open=1 -> next edge valve_open=0, state IDLE,
//    water_level=0.
//  2 start, load_weight=30 constant, sensor ramps 0->300 by 10/cycle -> valve_open after
//    10 cycles, water_level=300, fill_done pulse 1 cycle after sensor=300.
//  3 Boundaries: weights 20/50/80/81 -> water_level 150/300/450/600; samples 10,10,10,11
//    -> avg 10 -> 150.
//  4 load_weight=0 during WEIGH -> fault=1, fault_code=01, valve never opens; abort ->
//    IDLE.
//  5 weight 90, sensor stuck at 100 -> fault_code=10 exactly FILL_TIMEOUT cycles after
//    valve_open rose; valve closes same edge.
//  6 abort asserted with start in IDLE, and mid-FILL -> IDLE, no fill_done, valve closed
//    next edge.

Source files
------------

// File: rtl/wm_fill_pkg.sv
// Shared definitions for the washing-machine fill controller: FSM states,
// target water levels, fault codes and the load-size banding function.
package wm_fill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_WEIGH  = 3'd2,
        ST_FILL   = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam int unsigned SETTLE_CYCLES_DEF = 5;
    localparam int unsigned FILL_TIMEOUT_DEF  = 600;

    localparam logic [7:0] LOW_TH  = 8'd20;
    localparam logic [7:0] MED_TH  = 8'd50;
    localparam logic [7:0] HIGH_TH = 8'd80;

    localparam logic [9:0] LVL_LOW   = 10'd150;
    localparam logic [9:0] LVL_MED   = 10'd300;
    localparam logic [9:0] LVL_HIGH  = 10'd450;
    localparam logic [9:0] LVL_XHIGH = 10'd600;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_EMPTY   = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    // A weight exactly on a threshold belongs to the lower band.
    function automatic logic [9:0] band(input logic [7:0] w);
        if (w <= LOW_TH)       return LVL_LOW;
        else if (w <= MED_TH)  return LVL_MED;
        else if (w <= HIGH_TH) return LVL_HIGH;
        else                   return LVL_XHIGH;
    endfunction

endpackage

// File: rtl/wm_weight_averager.sv
// Accumulates four consecutive load-cell samples while enabled; on the fourth
// sample presents the truncated average (including that sample) with a done pulse.
module wm_weight_averager
    import wm_fill_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [7:0] sample,
    output logic [7:0] avg,
    output logic       done
);

    logic [9:0] sum_q, sum_d;
    logic [1:0] cnt_q, cnt_d;
    logic [9:0] sum_next;

    always_comb begin
        sum_next = sum_q + {2'b00, sample};
        avg      = sum_next[9:2];
        done     = sample_en && (cnt_q == 2'd3);
        sum_d    = '0;
        cnt_d    = '0;
        // Accumulator is cleared whenever sampling is not active, so each weigh starts fresh.
        if (sample_en && !done) begin
            sum_d = sum_next;
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/washing_machine_fill_controller.sv
// Water-fill sequencer: settle, weigh, pick target level, fill until the level
// sensor reaches target, with empty-drum and fill-timeout faults.
module washing_machine_fill_controller
    import wm_fill_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned FILL_TIMEOUT  = FILL_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] load_weight,
    input  logic [9:0] water_sensor,
    output logic [9:0] water_level,
    output logic       valve_open,
    output logic       busy,
    output logic       fill_done,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TO_W     = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic [9:0]          water_level_q, water_level_d;
    logic                valve_open_q, valve_open_d;
    logic                busy_q, busy_d;
    logic                fill_done_q, fill_done_d;
    logic                fault_q, fault_d;
    logic [1:0]          fault_code_q, fault_code_d;

    logic       avg_en;
    logic [7:0] avg;
    logic       avg_done;

    assign avg_en = (state_q == ST_WEIGH) && !abort;

    wm_weight_averager u_avg (
        .clk       (clk),
        .reset     (reset),
        .sample_en (avg_en),
        .sample    (load_weight),
        .avg       (avg),
        .done      (avg_done)
    );

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        tcnt_d        = tcnt_q;
        water_level_d = water_level_q;
        fault_code_d  = fault_code_q;

        if (abort) begin
            state_d      = ST_IDLE;
            settle_d     = '0;
            tcnt_d       = '0;
            fault_code_d = FC_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_d  = ST_WEIGH;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_WEIGH: begin
                    if (avg_done) begin
                        if (avg == 8'd0) begin
                            state_d      = ST_FAULT;
                            fault_code_d = FC_EMPTY;
                        end else begin
                            state_d       = ST_FILL;
                            water_level_d = band(avg);
                            tcnt_d        = '0;
                        end
                    end
                end
                ST_FILL: begin
                    // Reaching target takes priority over the timeout on the same cycle.
                    if (water_sensor >= water_level_q) begin
                        state_d = ST_DONE;
                    end else if (tcnt_q == TO_W'(FILL_TIMEOUT - 1)) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_TIMEOUT;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end

        valve_open_d = (state_d == ST_FILL);
        busy_d       = (state_d == ST_WEIGH) || (state_d == ST_FILL);
        fill_done_d  = (state_q == ST_FILL) && (state_d == ST_DONE);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            tcnt_q        <= '0;
            water_level_q <= '0;
            valve_open_q  <= 1'b0;
            busy_q        <= 1'b0;
            fill_done_q   <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            tcnt_q        <= tcnt_d;
            water_level_q <= water_level_d;
            valve_open_q  <= valve_open_d;
            busy_q        <= busy_d;
            fill_done_q   <= fill_done_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    assign water_level = water_level_q;
    assign valve_open  = valve_open_q;
    assign busy        = busy_q;
    assign fill_done   = fill_done_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_washing_machine_fill_controller.sv
// Directed bench for the fill controller: reset, latency, banding, faults and abort.
`timescale 1ns/1ps
module tb_washing_machine_fill_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] load_weight;
    logic [9:0] water_sensor;
    logic [9:0] water_level;
    logic       valve_open;
    logic       busy;
    logic       fill_done;
    logic       fault;
    logic [1:0] fault_code;

    int n_cmp = 0;
    int n_err = 0;

    washing_machine_fill_controller #(
        .SETTLE_CYCLES (5),
        .FILL_TIMEOUT  (600)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .load_weight  (load_weight),
        .water_sensor (water_sensor),
        .water_level  (water_level),
        .valve_open   (valve_open),
        .busy         (busy),
        .fill_done    (fill_done),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start pulse then 5 settle edges; afterwards the next 4 edges sample the weight.
    task automatic start_and_settle();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("settle_busy", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        check("weigh_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_to_fill(input logic [7:0] w, input logic [9:0] exp_lvl);
        load_weight = w;
        start_and_settle();
        repeat (3) tick();
        check("weigh_valve", {31'd0, valve_open}, 32'd0);
        tick();
        check("fill_valve", {31'd0, valve_open}, 32'd1);
        check("fill_level", {22'd0, water_level}, {22'd0, exp_lvl});
    endtask

    task automatic weigh_seq(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3,
                             input logic [9:0] exp_lvl);
        start_and_settle();
        load_weight = w0; tick();
        load_weight = w1; tick();
        load_weight = w2; tick();
        load_weight = w3; tick();
        check("seq_valve", {31'd0, valve_open}, 32'd1);
        check("seq_level", {22'd0, water_level}, {22'd0, exp_lvl});
        water_sensor = 10'd1023;
        tick();
        check("seq_done", {31'd0, fill_done}, 32'd1);
        water_sensor = 10'd0;
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        load_weight  = 8'd0;
        water_sensor = 10'd0;
        tick();
        tick();
        check("rst_level", {22'd0, water_level}, 32'd0);
        check("rst_valve", {31'd0, valve_open}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, fill_done}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_code", {30'd0, fault_code}, 32'd0);
        reset = 1'b1;
        tick();

        // Nominal fill: weight 30 -> 300, sensor ramps by 10 per cycle.
        run_to_fill(8'd30, 10'd300);
        for (int k = 1; k <= 30; k++) begin
            water_sensor = 10'(k * 10);
            tick();
            if (k < 30) begin
                check("ramp_valve", {31'd0, valve_open}, 32'd1);
                check("ramp_nodone", {31'd0, fill_done}, 32'd0);
            end
        end
        check("ramp_done", {31'd0, fill_done}, 32'd1);
        check("ramp_valve_off", {31'd0, valve_open}, 32'd0);
        check("ramp_busy_off", {31'd0, busy}, 32'd0);
        tick();
        check("done_pulse_end", {31'd0, fill_done}, 32'd0);
        check("level_held", {22'd0, water_level}, 32'd300);
        water_sensor = 10'd0;

        // Band boundaries with sensor already above target: done after one fill cycle.
        begin
            logic [7:0] ws [4] = '{8'd20, 8'd50, 8'd80, 8'd81};
            logic [9:0] ls [4] = '{10'd150, 10'd300, 10'd450, 10'd600};
            for (int i = 0; i < 4; i++) begin
                run_to_fill(ws[i], ls[i]);
                water_sensor = 10'd1023;
                tick();
                check("band_done", {31'd0, fill_done}, 32'd1);
                check("band_valve_off", {31'd0, valve_open}, 32'd0);
                water_sensor = 10'd0;
                tick();
            end
        end

        // Truncating average: 41/4 -> 10 and 83/4 -> 20, both LVL_LOW.
        weigh_seq(8'd10, 8'd10, 8'd10, 8'd11, 10'd150);
        weigh_seq(8'd20, 8'd20, 8'd20, 8'd23, 10'd150);
        weigh_seq(8'd50, 8'd50, 8'd50, 8'd53, 10'd300);

        // Empty drum.
        load_weight = 8'd0;
        start_and_settle();
        repeat (4) begin
            check("empty_valve", {31'd0, valve_open}, 32'd0);
            tick();
        end
        check("empty_fault", {31'd0, fault}, 32'd1);
        check("empty_code", {30'd0, fault_code}, 32'd1);
        check("empty_valve_end", {31'd0, valve_open}, 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("fault_latched", {31'd0, fault}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_clr_fault", {31'd0, fault}, 32'd0);
        check("abort_clr_code", {30'd0, fault_code}, 32'd0);

        // Fill timeout: weight 90 -> 600, sensor stuck at 100.
        water_sensor = 10'd100;
        run_to_fill(8'd90, 10'd600);
        repeat (599) tick();
        check("to_before_valve", {31'd0, valve_open}, 32'd1);
        check("to_before_fault", {31'd0, fault}, 32'd0);
        tick();
        check("to_fault", {31'd0, fault}, 32'd1);
        check("to_code", {30'd0, fault_code}, 32'd2);
        check("to_valve_off", {31'd0, valve_open}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Target reached on the timeout cycle: done wins.
        run_to_fill(8'd90, 10'd600);
        repeat (599) tick();
        water_sensor = 10'd600;
        tick();
        check("race_done", {31'd0, fill_done}, 32'd1);
        check("race_nofault", {31'd0, fault}, 32'd0);
        water_sensor = 10'd0;
        tick();

        // Abort together with start in IDLE.
        load_weight = 8'd30;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        repeat (10) tick();
        check("abort_start_valve", {31'd0, valve_open}, 32'd0);
        check("abort_start_busy", {31'd0, busy}, 32'd0);

        // Abort mid-fill.
        run_to_fill(8'd30, 10'd300);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        check("abort_fill_valve", {31'd0, valve_open}, 32'd0);
        check("abort_fill_busy", {31'd0, busy}, 32'd0);
        check("abort_fill_done", {31'd0, fill_done}, 32'd0);
        check("abort_fill_level", {22'd0, water_level}, 32'd300);
        abort = 1'b0;
        water_sensor = 10'd1023;
        tick();
        check("abort_no_done", {31'd0, fill_done}, 32'd0);
        water_sensor = 10'd0;

        // Reset mid-fill.
        run_to_fill(8'd60, 10'd450);
        tick();
        reset = 1'b0;
        tick();
        check("rstfill_valve", {31'd0, valve_open}, 32'd0);
        check("rstfill_level", {22'd0, water_level}, 32'd0);
        check("rstfill_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();
        run_to_fill(8'd81, 10'd600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
